cv32e40s_instr_obi_arbiter: RTL and testbench

- Shares the single instruction-side OBI master port between two requesters:
  - r0: prefetcher, sequential fetch.
  - r1: pointer fetch, used for CLIC vector and table-jump pointers.
- Enforces the OBI address-phase stability rule and caps outstanding transactions.
- Routes in-order responses back to the issuing requester and discards responses belonging to killed transactions.
- Sits between the IF-stage fetch logic and the core's instruction OBI interface, upstream of the RVFI instruction tracker.

---
 rtl/cv32e40s_instr_obi_arbiter.sv | 157 +++++++++++++++
 tb/tb_cv32e40s_instr_obi_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_instr_obi_arbiter.sv
// Instruction-side OBI arbiter: prefetcher (r0) and pointer fetch (r1) share one OBI master port.
// Define CV32E40S_INSTR_ARB_RR_EN for round-robin arbitration instead of fixed r1-over-r0 priority.
module cv32e40s_instr_obi_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill_i,
    input  logic             r0_req_i,
    input  logic [31:0]      r0_addr_i,
    input  logic [2:0]       r0_prot_i,
    output logic             r0_gnt_o,
    output logic             r0_rvalid_o,
    input  logic             r1_req_i,
    input  logic [31:0]      r1_addr_i,
    input  logic [2:0]       r1_prot_i,
    output logic             r1_gnt_o,
    output logic             r1_rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic             obi_req_o,
    output logic [31:0]      obi_addr_o,
    output logic [2:0]       obi_prot_o,
    input  logic             obi_gnt_i,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    input  logic             obi_err_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, HELD} state_e;

    state_e                     state_q, state_d;
    logic                       hold_owner_q, hold_discard_q;
    logic [31:0]                hold_addr_q;
    logic [2:0]                 hold_prot_q;
    logic [MAX_OUTSTANDING-1:0] fifo_owner_q, fifo_discard_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;

    logic sel_r1, issue, push, pop, push_owner, push_discard;
    logic fwd_gnt, fwd_rvalid, head_owner, head_discard;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef CV32E40S_INSTR_ARB_RR_EN
    logic last_owner_q;  // 1: r1 was granted last

    assign sel_r1 = r1_req_i && (!r0_req_i || !last_owner_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;
        end else if (fwd_gnt) begin
            last_owner_q <= push_owner;
        end
    end
`else
    assign sel_r1 = r1_req_i;
`endif

    // Credit comes from the registered count only; a same-cycle rvalid does not free a slot.
    assign issue = (state_q == IDLE) && !kill_i && (count_q < CNT_W'(MAX_OUTSTANDING))
                   && (r0_req_i || r1_req_i);

    always_comb begin
        state_d      = state_q;
        obi_req_o    = 1'b0;
        obi_addr_o   = hold_addr_q;
        obi_prot_o   = hold_prot_q;
        push_owner   = hold_owner_q;
        push_discard = hold_discard_q | kill_i;
        if (state_q == HELD) begin
            obi_req_o = 1'b1;
            if (obi_gnt_i) state_d = IDLE;
        end else if (issue) begin
            obi_req_o    = 1'b1;
            obi_addr_o   = sel_r1 ? r1_addr_i : r0_addr_i;
            obi_prot_o   = sel_r1 ? r1_prot_i : r0_prot_i;
            push_owner   = sel_r1;
            push_discard = 1'b0;
            if (!obi_gnt_i) state_d = HELD;
        end
    end

    assign push         = obi_req_o && obi_gnt_i;
    assign pop          = obi_rvalid_i && (count_q != '0);
    assign head_owner   = fifo_owner_q[rd_ptr_q];
    assign head_discard = fifo_discard_q[rd_ptr_q];
    assign fwd_gnt      = push && !push_discard && !kill_i;
    assign fwd_rvalid   = pop && !head_discard && !kill_i;

    assign r0_gnt_o      = fwd_gnt && !push_owner;
    assign r1_gnt_o      = fwd_gnt && push_owner;
    assign r0_rvalid_o   = fwd_rvalid && !head_owner;
    assign r1_rvalid_o   = fwd_rvalid && head_owner;
    assign rdata_o       = obi_rdata_i;
    assign err_o         = obi_err_i;
    assign outstanding_o = count_q;
    assign busy_o        = (state_q == HELD) || (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hold_owner_q   <= 1'b0;
            hold_discard_q <= 1'b0;
            hold_addr_q    <= '0;
            hold_prot_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && issue && !obi_gnt_i) begin
                hold_owner_q   <= push_owner;
                hold_discard_q <= 1'b0;
                hold_addr_q    <= obi_addr_o;
                hold_prot_q    <= obi_prot_o;
            end else if (kill_i) begin
                hold_discard_q <= 1'b1;
            end
        end
    end

    // Kill marks every slot; a slot written in the same cycle takes its own discard value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_owner_q   <= '0;
            fifo_discard_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            if (kill_i) fifo_discard_q <= '1;
            if (push) begin
                fifo_owner_q[wr_ptr_q]   <= push_owner;
                fifo_discard_q[wr_ptr_q] <= push_discard;
                wr_ptr_q                 <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_rvalid_with_empty_fifo: assert property (@(posedge clk) disable iff (!rst_n)
        obi_rvalid_i |-> (count_q != '0));
    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_cv32e40s_instr_obi_arbiter.sv
// Directed bench for cv32e40s_instr_obi_arbiter (MAX_OUTSTANDING=2, fixed priority build).
module tb_cv32e40s_instr_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kill_i;
    logic        r0_req_i, r1_req_i;
    logic [31:0] r0_addr_i, r1_addr_i;
    logic [2:0]  r0_prot_i, r1_prot_i;
    logic        r0_gnt_o, r0_rvalid_o, r1_gnt_o, r1_rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        obi_req_o;
    logic [31:0] obi_addr_o;
    logic [2:0]  obi_prot_o;
    logic        obi_gnt_i, obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [1:0]  outstanding_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40s_instr_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n), .kill_i(kill_i),
        .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_prot_i(r0_prot_i),
        .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o),
        .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_prot_i(r1_prot_i),
        .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_prot_o(obi_prot_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
        .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks follow 2ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0; kill_i = 1'b0;
        r0_req_i = 1'b0; r0_addr_i = '0; r0_prot_i = '0;
        r1_req_i = 1'b0; r1_addr_i = '0; r1_prot_i = '0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        cyc(); cyc();
        settle();
        chk("rst_obi_req", obi_req_o, 0);
        chk("rst_r0_gnt", r0_gnt_o, 0);
        chk("rst_r1_rvalid", r1_rvalid_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_busy", busy_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single r0 fetch, immediate grant, response next cycle
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0100; r0_prot_i = 3'b101; obi_gnt_i = 1'b1;
        settle();
        chk("t1_obi_req", obi_req_o, 1);
        chk("t1_obi_addr", obi_addr_o, 32'h0000_0100);
        chk("t1_obi_prot", obi_prot_o, 3'b101);
        chk("t1_r0_gnt", r0_gnt_o, 1);
        chk("t1_r1_gnt", r1_gnt_o, 0);
        cyc();
        r0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEAD_BEEF; obi_err_i = 1'b1;
        settle();
        chk("t1_outstanding1", outstanding_o, 1);
        chk("t1_r0_rvalid", r0_rvalid_o, 1);
        chk("t1_r1_rvalid", r1_rvalid_o, 0);
        chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("t1_err", err_o, 1);
        chk("t1_obi_req_idle", obi_req_o, 0);
        cyc();
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
        settle();
        chk("t1_outstanding0", outstanding_o, 0);
        chk("t1_busy0", busy_o, 0);

        // Both request: r1 first, then r0; responses return in order
        cyc();
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0104; r0_prot_i = 3'b000;
        r1_req_i = 1'b1; r1_addr_i = 32'h0000_2000; r1_prot_i = 3'b011;
        obi_gnt_i = 1'b1;
        settle();
        chk("t2_addr_r1", obi_addr_o, 32'h0000_2000);
        chk("t2_prot_r1", obi_prot_o, 3'b011);
        chk("t2_r1_gnt", r1_gnt_o, 1);
        chk("t2_r0_gnt_lose", r0_gnt_o, 0);
        cyc();
        r1_req_i = 1'b0;
        settle();
        chk("t2_addr_r0", obi_addr_o, 32'h0000_0104);
        chk("t2_r0_gnt", r0_gnt_o, 1);
        chk("t2_r1_gnt_off", r1_gnt_o, 0);
        cyc();
        r0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h1111_1111;
        settle();
        chk("t2_outstanding2", outstanding_o, 2);
        chk("t2_resp1_r1", r1_rvalid_o, 1);
        chk("t2_resp1_r0", r0_rvalid_o, 0);
        cyc();
        obi_rdata_i = 32'h2222_2222;
        settle();
        chk("t2_resp2_r0", r0_rvalid_o, 1);
        chk("t2_resp2_r1", r1_rvalid_o, 0);
        chk("t2_resp2_data", rdata_o, 32'h2222_2222);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        chk("t2_outstanding0", outstanding_o, 0);

        // Outstanding cap: two grants, then request drops; credit only the cycle after rvalid
        cyc();
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0300; obi_gnt_i = 1'b1;
        settle();
        chk("t3_gnt_a", r0_gnt_o, 1);
        cyc();
        settle();
        chk("t3_gnt_b", r0_gnt_o, 1);
        chk("t3_outstanding1", outstanding_o, 1);
        cyc();
        settle();
        chk("t3_capped_req", obi_req_o, 0);
        chk("t3_capped_gnt", r0_gnt_o, 0);
        chk("t3_outstanding2", outstanding_o, 2);
        cyc();
        obi_rvalid_i = 1'b1;
        settle();
        chk("t3_no_same_cycle_credit", obi_req_o, 0);
        chk("t3_rvalid", r0_rvalid_o, 1);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        chk("t3_req_after_credit", obi_req_o, 1);
        chk("t3_gnt_after_credit", r0_gnt_o, 1);
        chk("t3_outstanding1b", outstanding_o, 1);
        cyc();
        r0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1;
        settle();
        chk("t3_drain2", outstanding_o, 2);
        cyc();
        settle();
        chk("t3_drain1", outstanding_o, 1);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        chk("t3_drain0", outstanding_o, 0);

        // Address-phase stability while waiting for grant
        cyc();
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0200; r0_prot_i = 3'b100;
        settle();
        chk("t4_req_c0", obi_req_o, 1);
        chk("t4_addr_c0", obi_addr_o, 32'h0000_0200);
        chk("t4_nogrant", r0_gnt_o, 0);
        cyc();
        settle();
        chk("t4_busy_held", busy_o, 1);
        cyc();
        r0_req_i = 1'b0; r0_addr_i = 32'h0000_0999; r0_prot_i = 3'b000;
        settle();
        chk("t4_req_c2", obi_req_o, 1);
        chk("t4_addr_c2", obi_addr_o, 32'h0000_0200);
        chk("t4_prot_c2", obi_prot_o, 3'b100);
        cyc();
        obi_gnt_i = 1'b1;
        settle();
        chk("t4_addr_gnt", obi_addr_o, 32'h0000_0200);
        chk("t4_r0_gnt", r0_gnt_o, 1);
        cyc();
        obi_gnt_i = 1'b0;
        settle();
        chk("t4_req_released", obi_req_o, 0);
        chk("t4_outstanding1", outstanding_o, 1);
        cyc();
        obi_rvalid_i = 1'b1;
        settle();
        chk("t4_rvalid", r0_rvalid_o, 1);
        cyc();
        obi_rvalid_i = 1'b0;

        // Kill with two outstanding: both responses discarded, later r1 fetch normal
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0400; obi_gnt_i = 1'b1;
        cyc(); cyc();
        obi_gnt_i = 1'b0; kill_i = 1'b1;
        settle();
        chk("t5_kill_outstanding", outstanding_o, 2);
        chk("t5_kill_no_req", obi_req_o, 0);
        chk("t5_kill_no_gnt", r0_gnt_o, 0);
        cyc();
        kill_i = 1'b0; r0_req_i = 1'b0; obi_rvalid_i = 1'b1;
        settle();
        chk("t5_discard_a", r0_rvalid_o, 0);
        cyc();
        settle();
        chk("t5_discard_b", r0_rvalid_o, 0);
        chk("t5_outstanding1", outstanding_o, 1);
        cyc();
        obi_rvalid_i = 1'b0; r1_req_i = 1'b1; r1_addr_i = 32'h0000_0500; obi_gnt_i = 1'b1;
        settle();
        chk("t5_outstanding0", outstanding_o, 0);
        chk("t5_r1_gnt", r1_gnt_o, 1);
        cyc();
        r1_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1;
        settle();
        chk("t5_r1_rvalid", r1_rvalid_o, 1);
        cyc();
        obi_rvalid_i = 1'b0;

        // Kill while held: late grant and its response are suppressed
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0600;
        settle();
        chk("t6_req", obi_req_o, 1);
        cyc();
        r0_req_i = 1'b0; kill_i = 1'b1;
        settle();
        chk("t6_kill_req_held", obi_req_o, 1);
        chk("t6_kill_addr_held", obi_addr_o, 32'h0000_0600);
        cyc();
        kill_i = 1'b0; obi_gnt_i = 1'b1;
        settle();
        chk("t6_req_at_gnt", obi_req_o, 1);
        chk("t6_gnt_suppressed", r0_gnt_o, 0);
        cyc();
        obi_gnt_i = 1'b0;
        settle();
        chk("t6_outstanding1", outstanding_o, 1);
        chk("t6_busy1", busy_o, 1);
        cyc();
        obi_rvalid_i = 1'b1;
        settle();
        chk("t6_rvalid_suppressed", r0_rvalid_o, 0);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        chk("t6_busy0", busy_o, 0);

        // Reset mid-transaction clears tracking asynchronously
        cyc();
        r0_req_i = 1'b1; r0_addr_i = 32'h0000_0700; obi_gnt_i = 1'b1;
        cyc();
        r0_req_i = 1'b0; obi_gnt_i = 1'b0;
        settle();
        chk("t7_outstanding1", outstanding_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_clear", outstanding_o, 0);
        chk("t7_async_busy", busy_o, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        settle();
        chk("t7_after_reset", outstanding_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
